// File: rtl/sa_weight_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_weight_loader_pkg
//  Description : Shared spatial-array parameters. The word width, buffer depth
//                and array mode encodings live here so the weight loader and
//                the array cell agree on them. Also holds the loader FSM state
//                type and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_weight_loader_pkg;

    // One weight word is an IEEE754 single-precision value.
    localparam int SA_DATA_WIDTH      = 32;
    // Default number of array columns fed by the loader.
    localparam int SA_NUM_COLS        = 4;
    // Words held by each cell column's move buffer.
    localparam int SA_MOVE_BUFF_DEPTH = 16;

    // Array mode encodings. Element-wise mode makes the move buffers writable.
    localparam logic SA_MODE_ACCUMULATE  = 1'b0;
    localparam logic SA_MODE_ELEMENTWISE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FINISH = 2'd2
    } loader_state_t;

    // Counter width for an index range of n. A single-entry range still
    // needs a one-bit counter to be legal.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sa_weight_loader_pkg
`default_nettype wire

// File: rtl/sa_weight_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_weight_loader_if
//  Description : Signal bundle between the weight loader and its controller /
//                memory side / array columns.
//                  start              - single-cycle load request
//                  in_data/in_valid   - weight word from memory
//                  in_ready           - loader accepts in_data this cycle
//                  move_buff_out      - per-column word, column c at
//                                       [c*DATA_WIDTH +: DATA_WIDTH]
//                  move_buff_out_valid- per-column push strobe
//                  mode_out           - array mode (1 = element-wise)
//                  busy/done          - load in progress / last word pushed
//                  start_err          - sticky: start seen while busy
//                slave modport is the loader, master is the controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sa_weight_loader_if
    import sa_weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int NUM_COLS   = SA_NUM_COLS
);
    logic                           start;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_COLS*DATA_WIDTH-1:0] move_buff_out;
    logic [NUM_COLS-1:0]            move_buff_out_valid;
    logic                           mode_out;
    logic                           busy;
    logic                           done;
    logic                           start_err;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, move_buff_out, move_buff_out_valid,
               mode_out, busy, done, start_err
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, move_buff_out, move_buff_out_valid,
               mode_out, busy, done, start_err
    );

endinterface : sa_weight_loader_if
`default_nettype wire

// File: rtl/sa_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sa_weight_loader
//  Description : Streams NUM_COLS*MOVE_BUFF_DEPTH weight words from memory into
//                the move buffers of a spatial array, column by column. Each
//                accepted word is pushed to the current column one cycle later
//                with a one-hot strobe. The array is held in element-wise mode
//                for the whole load.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - sa_weight_loader_if.slave (handshake and column bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module sa_weight_loader
    import sa_weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = SA_DATA_WIDTH,
    parameter int NUM_COLS        = SA_NUM_COLS,
    parameter int MOVE_BUFF_DEPTH = SA_MOVE_BUFF_DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sa_weight_loader_if.slave bus
);

    localparam int COL_W  = clog2_min1(NUM_COLS);
    localparam int WORD_W = clog2_min1(MOVE_BUFF_DEPTH);

    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(NUM_COLS - 1);
    localparam logic [WORD_W-1:0] c_WORD_LAST = WORD_W'(MOVE_BUFF_DEPTH - 1);

    loader_state_t                  r_state;
    loader_state_t                  w_state_next;
    logic [COL_W-1:0]               r_col_idx;
    logic [WORD_W-1:0]              r_word_idx;
    logic [NUM_COLS*DATA_WIDTH-1:0] r_buff_out;
    logic [NUM_COLS-1:0]            r_buff_vld;
    logic                           r_start_err;

    logic w_xfer;
    logic w_last_word;
    logic w_in_ready;
    logic w_busy;
    logic w_done;

    // in_ready is high exactly in LOAD, so a transfer needs only in_valid there.
    assign w_xfer      = (r_state == ST_LOAD) && bus.in_valid;
    assign w_last_word = (r_col_idx == c_COL_LAST) && (r_word_idx == c_WORD_LAST);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_xfer && w_last_word) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // The final word's push strobe is on the bus during this cycle.
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Column / word position. At the last word of the last column the column
    // index is left alone; the FSM leaves LOAD and the next start clears it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_idx  <= '0;
            r_word_idx <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_col_idx  <= '0;
            r_word_idx <= '0;
        end else if (w_xfer) begin
            if (r_word_idx == c_WORD_LAST) begin
                r_word_idx <= '0;
                if (r_col_idx != c_COL_LAST) begin
                    r_col_idx <= r_col_idx + 1'b1;
                end
            end else begin
                r_word_idx <= r_word_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Column push: one cycle after a transfer. Only the addressed column's
    // data lane is written, so every lane holds its last pushed word.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buff_out <= '0;
            r_buff_vld <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                r_buff_vld[c] <= w_xfer && (r_col_idx == COL_W'(c));
                if (w_xfer && (r_col_idx == COL_W'(c))) begin
                    r_buff_out[c*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
                end
            end
        end
    end

    // Sticky until reset: a start outside IDLE (LOAD or FINISH) is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_err <= 1'b0;
        end else if (bus.start && (r_state != ST_IDLE)) begin
            r_start_err <= 1'b1;
        end
    end

    assign bus.in_ready            = w_in_ready;
    assign bus.busy                = w_busy;
    assign bus.done                = w_done;
    assign bus.mode_out            = w_busy ? SA_MODE_ELEMENTWISE : SA_MODE_ACCUMULATE;
    assign bus.move_buff_out       = r_buff_out;
    assign bus.move_buff_out_valid = r_buff_vld;
    assign bus.start_err           = r_start_err;

endmodule : sa_weight_loader
`default_nettype wire

// File: tb/tb_sa_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_weight_loader
//  Description : Directed self-checking bench for sa_weight_loader. DUT A is
//                the 4-column / depth-16 loader, DUT B a 1-column / depth-2
//                loader. Inputs change and outputs are sampled on the falling
//                clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sa_weight_loader;

    localparam int DW    = 32;
    localparam int NC    = 4;
    localparam int DEP   = 16;
    localparam int TOTAL = NC * DEP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sa_weight_loader_if #(.DATA_WIDTH(DW), .NUM_COLS(NC)) bus_a ();
    sa_weight_loader_if #(.DATA_WIDTH(DW), .NUM_COLS(1))  bus_b ();

    sa_weight_loader #(
        .DATA_WIDTH      (DW),
        .NUM_COLS        (NC),
        .MOVE_BUFF_DEPTH (DEP)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    sa_weight_loader #(
        .DATA_WIDTH      (DW),
        .NUM_COLS        (1),
        .MOVE_BUFF_DEPTH (2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full load on DUT A. Word k carries data k and belongs to column k/DEP.
    // toggle   : in_valid alternates 0/1 instead of staying high
    // err_at   : pulse start when this many words have been accepted (-1 = no)
    // rst_at   : assert reset when this many words have been accepted (-1 = no)
    task automatic run_load(input bit toggle, input int err_at, input int rst_at);
        int          acc       = 0;
        bit          pending   = 1'b0;
        int          pend_word = 0;
        int          strobes   = 0;
        int          dones     = 0;
        int          cyc       = 0;
        bit          drive;
        bit          err_sent  = 1'b0;
        logic [63:0] exp_vld;

        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;

        while ((acc < TOTAL || pending) && cyc < 2000) begin
            cyc++;
            check("a_ready", 64'(bus_a.in_ready), 64'(acc < TOTAL));
            check("a_mode",  64'(bus_a.mode_out), 64'd1);
            check("a_busy",  64'(bus_a.busy),     64'd1);
            if (pending) begin
                exp_vld = 64'd1 << (pend_word / DEP);
                check("a_vld",  64'(bus_a.move_buff_out_valid), exp_vld);
                check("a_data", 64'(bus_a.move_buff_out[(pend_word/DEP)*DW +: DW]), 64'(pend_word));
                strobes++;
            end else begin
                check("a_vld_idle", 64'(bus_a.move_buff_out_valid), 64'd0);
            end
            check("a_done", 64'(bus_a.done), 64'(pending && (pend_word == TOTAL - 1)));
            if (bus_a.done) dones++;
            pending = 1'b0;

            if (rst_at >= 0 && acc == rst_at) begin
                check("a_err_before_rst", 64'(bus_a.start_err), 64'd1);
                rst_n          = 1'b0;
                bus_a.in_valid = 1'b0;
                #1;
                check("rst_ready", 64'(bus_a.in_ready),            64'd0);
                check("rst_vld",   64'(bus_a.move_buff_out_valid), 64'd0);
                check("rst_data",  64'(|bus_a.move_buff_out),      64'd0);
                check("rst_mode",  64'(bus_a.mode_out),            64'd0);
                check("rst_busy",  64'(bus_a.busy),                64'd0);
                check("rst_done",  64'(bus_a.done),                64'd0);
                check("rst_err",   64'(bus_a.start_err),           64'd0);
                @(negedge clk);
                rst_n          = 1'b1;
                bus_a.in_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("post_rst_vld",   64'(bus_a.move_buff_out_valid), 64'd0);
                    check("post_rst_ready", 64'(bus_a.in_ready),            64'd0);
                    check("post_rst_mode",  64'(bus_a.mode_out),            64'd0);
                end
                bus_a.in_valid = 1'b0;
                return;
            end

            if (err_at >= 0 && acc == err_at && !err_sent) begin
                bus_a.start = 1'b1;
                err_sent    = 1'b1;
            end else begin
                bus_a.start = 1'b0;
            end

            drive = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (acc < TOTAL) begin
                bus_a.in_valid = drive;
                bus_a.in_data  = DW'(acc);
                if (drive) begin
                    pending   = 1'b1;
                    pend_word = acc;
                    acc++;
                end
            end else begin
                bus_a.in_valid = 1'b0;
            end
            @(negedge clk);
        end

        bus_a.start    = 1'b0;
        bus_a.in_valid = 1'b0;
        check("a_timeout",    64'(cyc >= 2000), 64'd0);
        check("a_end_mode",   64'(bus_a.mode_out),            64'd0);
        check("a_end_busy",   64'(bus_a.busy),                64'd0);
        check("a_end_ready",  64'(bus_a.in_ready),            64'd0);
        check("a_end_vld",    64'(bus_a.move_buff_out_valid), 64'd0);
        check("a_end_done",   64'(bus_a.done),                64'd0);
        check("a_strobes",    64'(strobes), 64'(TOTAL));
        check("a_done_count", 64'(dones),   64'd1);
        // Column 3 keeps its last word (63) after the load.
        check("a_hold_col3",  64'(bus_a.move_buff_out[3*DW +: DW]), 64'd63);
        check("a_hold_col0",  64'(bus_a.move_buff_out[0*DW +: DW]), 64'd15);
    endtask

    initial begin
        bus_a.start    = 1'b0;
        bus_a.in_data  = '0;
        bus_a.in_valid = 1'b0;
        bus_b.start    = 1'b0;
        bus_b.in_data  = '0;
        bus_b.in_valid = 1'b0;

        #1;
        check("init_ready", 64'(bus_a.in_ready),            64'd0);
        check("init_vld",   64'(bus_a.move_buff_out_valid), 64'd0);
        check("init_mode",  64'(bus_a.mode_out),            64'd0);
        check("init_busy",  64'(bus_a.busy),                64'd0);
        check("init_err",   64'(bus_a.start_err),           64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full load, in_valid always high.
        run_load(1'b0, -1, -1);
        check("full_err", 64'(bus_a.start_err), 64'd0);

        // in_valid toggling every cycle.
        run_load(1'b1, -1, -1);
        check("toggle_err", 64'(bus_a.start_err), 64'd0);

        // start during LOAD at word 10: ignored, error sticky.
        run_load(1'b0, 10, -1);
        check("busy_start_err", 64'(bus_a.start_err), 64'd1);
        repeat (3) @(negedge clk);
        check("busy_start_err_sticky", 64'(bus_a.start_err), 64'd1);

        // DUT B: one column, depth two.
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start    = 1'b0;
        check("b_ready0", 64'(bus_b.in_ready), 64'd1);
        check("b_mode0",  64'(bus_b.mode_out), 64'd1);
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = 32'h3F80_0000;
        @(negedge clk);
        check("b_vld1",   64'(bus_b.move_buff_out_valid), 64'd1);
        check("b_data1",  64'(bus_b.move_buff_out),       64'h3F80_0000);
        check("b_done1",  64'(bus_b.done),                64'd0);
        check("b_ready1", 64'(bus_b.in_ready),            64'd1);
        bus_b.in_data  = 32'h4000_0000;
        @(negedge clk);
        check("b_vld2",   64'(bus_b.move_buff_out_valid), 64'd1);
        check("b_data2",  64'(bus_b.move_buff_out),       64'h4000_0000);
        check("b_done2",  64'(bus_b.done),                64'd1);
        check("b_ready2", 64'(bus_b.in_ready),            64'd0);
        check("b_mode2",  64'(bus_b.mode_out),            64'd1);
        bus_b.in_valid = 1'b0;
        bus_b.start    = 1'b1;      // coincides with FINISH: must be dropped
        @(negedge clk);
        bus_b.start = 1'b0;
        check("b_vld3",   64'(bus_b.move_buff_out_valid), 64'd0);
        check("b_hold3",  64'(bus_b.move_buff_out),       64'h4000_0000);
        check("b_busy3",  64'(bus_b.busy),                64'd0);
        check("b_mode3",  64'(bus_b.mode_out),            64'd0);
        check("b_err3",   64'(bus_b.start_err),           64'd1);
        @(negedge clk);
        check("b_busy4",  64'(bus_b.busy),                64'd0);
        check("b_ready4", 64'(bus_b.in_ready),            64'd0);

        // Reset at word 20, then a fresh full load from column 0 word 0.
        run_load(1'b0, -1, 20);
        check("b_err_after_rst", 64'(bus_b.start_err), 64'd0);
        run_load(1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sa_weight_loader
`default_nettype wire

// File: doc/sa_weight_loader.md
SA_WEIGHT_LOADER -- requirements
Module: sa_weight_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one weight word (IEEE754 single).
REQ-002 SHALL have parameter NUM_COLS, default 4, number of spatial-array columns fed.
REQ-003 SHALL have parameter MOVE_BUFF_DEPTH, default 16, words loaded per column.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a full load.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  weight word from memory side.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 SHALL have port move_buff_out  output  NUM_COLS*DATA_WIDTH  per-column word to the top cell's move_buff_in; column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port move_buff_out_valid  output  NUM_COLS  per-column push strobe.
REQ-012 SHALL have port mode_out  output  1  array mode; 1 (element-wise, buffers writable) while busy.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the last word is pushed.
REQ-015 SHALL have port start_err  output  1  sticky flag, start seen while busy.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> FINISH -> IDLE.
REQ-017 IDLE: in_ready=0, busy=0; start=1 SHALL go to LOAD, clear col_idx and word_idx to 0.
REQ-018 LOAD: in_ready=1, busy=1; transfer occurs when in_valid && in_ready.
REQ-019 On a transfer, the next cycle SHALL drive move_buff_out column col_idx = in_data and move_buff_out_valid = one-hot(col_idx); all other valid bits 0 (latency 1 cycle).
REQ-020 move_buff_out_valid SHALL be all-zero in any cycle following no transfer; in_valid low stalls without loss.
REQ-021 word_idx SHALL increment per transfer; at MOVE_BUFF_DEPTH-1 it SHALL wrap to 0 and col_idx SHALL increment.
REQ-022 Transfer with col_idx=NUM_COLS-1 and word_idx=MOVE_BUFF_DEPTH-1 SHALL go to FINISH; in_ready SHALL drop the next cycle.
REQ-023 FINISH: lasts exactly one cycle, pulses done=1 coincident with the final push strobe, then returns to IDLE.
REQ-024 mode_out SHALL be 1 in LOAD and FINISH, 0 in IDLE.
REQ-025 start while busy SHALL be ignored and set start_err; start_err clears only on reset.
REQ-026 start coincident with FINISH SHALL be ignored (sets start_err); a new start is accepted from IDLE only.
REQ-027 move_buff_out data SHALL hold its last value when valid is 0.
REQ-028 Total accepted words per load SHALL be exactly NUM_COLS*MOVE_BUFF_DEPTH.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, col_idx=0, word_idx=0, in_ready=0, move_buff_out=0, move_buff_out_valid=0, mode_out=0, busy=0, done=0, start_err=0.
REQ-030 Reset mid-load SHALL abandon the load; no further strobes after rst_n deasserts until a new start.

Structure
REQ-031 DATA_WIDTH, MOVE_BUFF_DEPTH and mode encodings (accumulate=0, element-wise=1) SHALL live in the shared spatial-array parameter include, used by both this block and the array cell.
REQ-032 Counter widths SHALL be $clog2 of NUM_COLS and MOVE_BUFF_DEPTH (minimum 1).
REQ-033 No sub-module; single flat module.

Verification
REQ-034 Full load, NUM_COLS=4, DEPTH=16, in_valid always 1, data=0..63 -> col0 gets 0..15, col3 gets 48..63, done pulses once with word 63's strobe, 64 strobes total.
REQ-035 in_valid toggled 1/0 each cycle -> strobes only after valid cycles, order preserved, done after 64th accepted word.
REQ-036 start pulsed during LOAD at word 10 -> load unaffected, start_err=1 and sticky.
REQ-037 rst_n low at word 20 -> all outputs 0 immediately; after release no strobes; fresh start reloads from col0 word0.
REQ-038 NUM_COLS=1, DEPTH=2, data 0x3F800000,0x40000000 -> col0 strobes both, done on second, in_ready low the cycle after.
REQ-039 Check mode_out=1 throughout LOAD/FINISH and 0 in IDLE for every scenario above.
